ysyx_22050710_axi4_burst_sram: RTL
==================================

# ysyx_22050710_axi4_burst_sram

AXI4-full slave with an internal single-port SRAM array. It supports parametrised data, address, ID width and depth, and FIXED, INCR and WRAP bursts for both reads and writes. Narrow sizes, per-beat error responses, and fair read/write arbitration of the one SRAM port are included. It sits behind the crossbar as the next-generation memory endpoint for the npc core and the cache refill path.

## Interface
- DATA_WIDTH, 64: data bus width in bits (power of two, ≥32)
- ADDR_WIDTH, 32: address width
- ID_WIDTH, 4: AXI ID width
- MEM_WORDS, 1024: SRAM depth in DATA_WIDTH words
- BASE_ADDR, 32'h8000_0000: byte address of word 0
- STRB_WIDTH, DATA_WIDTH/8: derived, not overridden
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- i_aclk  in  1  clock
- i_arsetn  in  1  asynchronous active-low reset
- i_awid/i_awaddr/i_awlen/i_awsize/i_awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- i_awvalid in 1, o_awready out 1  AW handshake
- i_wdata/i_wstrb/i_wlast  in  DATA_WIDTH/STRB_WIDTH/1  write data
- i_wvalid in 1, o_wready out 1  W handshake
- o_bid/o_bresp  out  ID_WIDTH/2  write response
- o_bvalid out 1, i_bready in 1  B handshake
- i_arid/i_araddr/i_arlen/i_arsize/i_arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- i_arvalid in 1, o_arready out 1  AR handshake
- o_rid/o_rdata/o_rresp/o_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- o_rvalid out 1, i_rready in 1  R handshake
- i_{aw,ar}lock 2, i_{aw,ar}cache 4, i_{aw,ar}prot 3  in  accepted and ignored

## Operation
- Read FSM, R_IDLE→R_READ on ar_fire. The block captures id, addr, len, size and burst. It returns to R_IDLE on the r_fire with o_rlast. o_arready = R_IDLE.
- Write FSM, W_IDLE→W_DATA on aw_fire. W_DATA→W_RESP on the w_fire of beat len, counted internally. W_RESP→W_IDLE on b_fire. o_awready = W_IDLE.
- Read beat request: R_READ, beats outstanding, and (!o_rvalid || r_fire).
- Write beat request: W_DATA && i_wvalid. o_wready = W_DATA && write granted.
- Arbitration: one SRAM access per cycle. When both channels request, a round-robin priority bit picks the winner. The bit then points at the loser. An uncontested request is always granted.
- Next address:
  - FIXED: address unchanged.
  - INCR: addr + (1<<size).
  - WRAP: the low log2((len+1)<<size) bits increment modulo the wrap size; the upper bits are held.
- Beat SLVERR, per beat:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*STRB_WIDTH)
  - size > log2(STRB_WIDTH)
  - WRAP with len ∉ {1,3,7,15}; the address then advances as INCR
- Effect of an errored beat: the write is suppressed, o_rdata = 0, o_rresp = 2'b10.
- Writes: byte lanes are written per i_wstrb. SRAM word index = (addr−BASE_ADDR)>>log2(STRB_WIDTH). Narrow-lane placement is the master's duty.
- o_bresp = SLVERR if any beat errored, or if i_wlast disagrees with the internal last-beat count on any beat. Otherwise OKAY.
- AR and AW are independent and may fire in the same cycle. Read/write ordering to the same word follows grant order.
- 4 KB boundary crossing is not checked.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - FSMs go idle.
  - o_arready = o_awready = 1.
  - o_wready, o_rvalid, o_rlast, o_bvalid = 0.
  - o_rid, o_bid, o_rdata, o_rresp, o_bresp = 0.
  - SRAM contents are preserved.
  - Reset mid-burst aborts the burst without a response.
- ar_fire at T → first SRAM read at T+1 (if granted) → o_rvalid at T+2.
- With i_rready held high and no write contention, one beat per cycle.
- o_rdata, o_rid, o_rresp and o_rlast are registered and held stable while o_rvalid && !i_rready.
- aw_fire at T → o_wready is possible from T+1. Last w_fire at U → o_bvalid at U+1, held until i_bready.
- Under full contention each channel gets ≥1 grant every 2 cycles.

## Structure
- axi_defines.v holds the constants:
  - burst encodings FIXED 2'b00, INCR 2'b01, WRAP 2'b10
  - responses OKAY 2'b00, SLVERR 2'b10
- Sub-module ysyx_22050710_axi_burst_addr_gen computes next_addr and err from addr, len, size and burst, plus parameters. It is combinational, with two instances (read and write).
- The SRAM is a plain reg array inside the block.

## Test plan
- Write INCR len=3, size=3 at 0x8000_0000, data 0x11..0x44, strb 0xFF → then read INCR len=3 returns 0x11, 0x22, 0x33, 0x44 with rlast on beat 4, rresp OKAY, rid echoed.
- WRAP len=3, size=3 at 0x8000_0010 → beats hit 0x10, 0x18, 0x00, 0x08; FIXED len=2 → 3 beats all at the start address.
- Partial strb 0x0F over a word holding 0xFFFF_FFFF_FFFF_FFFF with data 0 → readback 0xFFFF_FFFF_0000_0000.
- INCR len=1 starting at the last word → beat 0 OKAY, beat 1 SLVERR with rdata 0; the same write → bresp SLVERR and the in-range beat is written.
- Concurrent AR len=7 and AW len=7 with rready/wvalid held high → both complete, with grants alternating every cycle under contention.
- Assert reset mid-read burst → o_rvalid drops immediately and o_arready = 1; a new read afterwards returns the correct data.

Source files
------------

// File: rtl/ysyx_22050710_axi4_burst_sram_pkg.sv
// Shared AXI encodings, FSM state types and helpers for the burst SRAM slave.
package ysyx_22050710_axi4_burst_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_READ} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // AXI only defines WRAP bursts of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_22050710_axi4_burst_sram_addr_gen.sv
// Combinational next-beat address and per-beat error decode for one AXI burst channel.
module ysyx_22050710_axi_burst_addr_gen
  import ysyx_22050710_axi4_burst_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_err
);

  localparam int                  STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0]          SIZE_MAX   = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH:0] ADDR_LO    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] ADDR_HI    = ADDR_LO + (ADDR_WIDTH+1)'(MEM_WORDS * STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;
  logic                  in_range;

  always_comb begin
    step      = ADDR_WIDTH'(1) << i_size;
    incr      = i_addr + step;
    wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    wrap_ok   = wrap_len_ok(i_len);
    in_range  = ({1'b0, i_addr} >= ADDR_LO) && ({1'b0, i_addr} < ADDR_HI);
    o_err     = !in_range || (i_size > SIZE_MAX) || ((i_burst == BURST_WRAP) && !wrap_ok);
    // An illegal WRAP length still walks forward like INCR so the beat count stays sane.
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = wrap_ok ? ((i_addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:     o_next_addr = incr;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_axi4_burst_sram.sv
// AXI4 slave over a single-port SRAM; read and write bursts share the array via round-robin.
module ysyx_22050710_axi4_burst_sram
  import ysyx_22050710_axi4_burst_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
  input  logic                    i_aclk,
  input  logic                    i_arsetn,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic [1:0]              i_awlock,
  input  logic [3:0]              i_awcache,
  input  logic [2:0]              i_awprot,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic [1:0]              i_arlock,
  input  logic [3:0]              i_arcache,
  input  logic [2:0]              i_arprot,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next, r_off;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [8:0]            r_left_q, r_left_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_err, r_req, r_gnt, r_fire;
  logic [IDX_W-1:0]      r_idx;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next, w_off;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_acc_err_q, w_acc_err_d, w_err_now;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_err, w_req, w_gnt, w_fire, w_last_beat, w_we;
  logic [IDX_W-1:0]      w_idx;

  logic                  prio_w_q, prio_w_d;
  logic                  unused_sideband;

  ysyx_22050710_axi_burst_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_rd_addr_gen (
    .i_addr(r_addr_q), .i_len(r_len_q), .i_size(r_size_q), .i_burst(r_burst_q),
    .o_next_addr(r_next), .o_err(r_err)
  );

  ysyx_22050710_axi_burst_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_wr_addr_gen (
    .i_addr(w_addr_q), .i_len(w_len_q), .i_size(w_size_q), .i_burst(w_burst_q),
    .o_next_addr(w_next), .o_err(w_err)
  );

  assign r_off = r_addr_q - BASE_ADDR;
  assign w_off = w_addr_q - BASE_ADDR;
  assign r_idx = r_off[ADDR_LSB +: IDX_W];
  assign w_idx = w_off[ADDR_LSB +: IDX_W];
  assign unused_sideband = ^{i_awlock, i_awcache, i_awprot, i_arlock, i_arcache, i_arprot, r_off, w_off};

  // A read beat is only requested when the output register is free or draining this cycle.
  assign r_fire      = rvalid_q && i_rready;
  assign r_req       = (r_state_q == R_READ) && (r_left_q != 9'd0) && (!rvalid_q || r_fire);
  assign w_req       = (w_state_q == W_DATA) && i_wvalid;
  assign r_gnt       = r_req && (!w_req || !prio_w_q);
  assign w_gnt       = w_req && (!r_req || prio_w_q);
  assign prio_w_d    = (r_req && w_req) ? r_gnt : prio_w_q;
  assign w_fire      = w_gnt;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_we        = w_fire && !w_err;
  assign w_err_now   = w_acc_err_q || w_err || (i_wlast != w_last_beat);

  assign o_arready = (r_state_q == R_IDLE);
  assign o_awready = (w_state_q == W_IDLE);
  assign o_wready  = w_gnt;
  assign o_rvalid  = rvalid_q;
  assign o_rdata   = rdata_q;
  assign o_rresp   = rresp_q;
  assign o_rlast   = rlast_q;
  assign o_rid     = r_id_q;
  assign o_bvalid  = bvalid_q;
  assign o_bresp   = bresp_q;
  assign o_bid     = w_id_q;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_left_d  = r_left_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (r_state_q == R_IDLE) begin
      if (i_arvalid) begin
        r_state_d = R_READ;
        r_id_d    = i_arid;
        r_addr_d  = i_araddr;
        r_len_d   = i_arlen;
        r_size_d  = i_arsize;
        r_burst_d = i_arburst;
        r_left_d  = {1'b0, i_arlen} + 9'd1;
      end
    end else begin
      if (r_fire) begin
        rvalid_d = 1'b0;
        if (rlast_q) r_state_d = R_IDLE;
      end
      if (r_gnt) begin
        rvalid_d = 1'b1;
        rdata_d  = r_err ? '0 : mem_q[r_idx];
        rresp_d  = r_err ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = (r_left_q == 9'd1);
        r_addr_d = r_next;
        r_left_d = r_left_q - 9'd1;
      end
    end
  end

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_acc_err_d = w_acc_err_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (i_awvalid) begin
          w_state_d   = W_DATA;
          w_id_d      = i_awid;
          w_addr_d    = i_awaddr;
          w_len_d     = i_awlen;
          w_size_d    = i_awsize;
          w_burst_d   = i_awburst;
          w_cnt_d     = 8'd0;
          w_acc_err_d = 1'b0;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_acc_err_d = w_err_now;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_now ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = w_next;
          end
        end
      end
      default: begin
        if (i_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_size_q    <= '0;
      r_burst_q   <= '0;
      r_left_q    <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_size_q    <= '0;
      w_burst_q   <= '0;
      w_cnt_q     <= '0;
      w_acc_err_q <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      prio_w_q    <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_addr_q    <= r_addr_d;
      r_len_q     <= r_len_d;
      r_size_q    <= r_size_d;
      r_burst_q   <= r_burst_d;
      r_left_q    <= r_left_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_addr_q    <= w_addr_d;
      w_len_q     <= w_len_d;
      w_size_q    <= w_size_d;
      w_burst_q   <= w_burst_d;
      w_cnt_q     <= w_cnt_d;
      w_acc_err_q <= w_acc_err_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      prio_w_q    <= prio_w_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge i_aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) mem_q[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule
